// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC accumulator slice:
//   - state_e   : controller states (IDLE, ACCUM, DONE)
//   - PRODUCT_W : width of the signed product from the Booth multiplier
//   - ACC_W_DEF : default accumulator/result width (legal 8..32)
//   - LEN_W_DEF : default job-length field width
// ---------------------------------------------------------------------------
package mac_pkg;

    localparam int PRODUCT_W = 8;
    localparam int ACC_W_DEF = 16;
    localparam int LEN_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage : mac_pkg

// File: rtl/mac_accumulator_sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
// Combinational sign-extend-and-add of an ACC_W-bit accumulator and an 8-bit
// signed product. The sum is formed in ACC_W+1 bits; signed overflow is
// flagged when the two top bits of that wide sum differ.
//
// Optional feature macro: MAC_SATURATE_EN
//   defined   : on overflow the sum clamps to the most positive / most
//               negative ACC_W-bit value
//   undefined : the sum wraps modulo 2^ACC_W
//
// Ports:
//   acc      in  ACC_W      current accumulator value (signed)
//   product  in  PRODUCT_W  product to add (signed)
//   sum      out ACC_W      next accumulator value
//   ovf      out 1          signed overflow of this addition
// ---------------------------------------------------------------------------
module sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]     acc,
    input  logic [PRODUCT_W-1:0] product,
    output logic [ACC_W-1:0]     sum,
    output logic                 ovf
);

    logic [ACC_W:0] acc_ext;
    logic [ACC_W:0] product_ext;
    logic [ACC_W:0] sum_wide;

    assign acc_ext     = {acc[ACC_W-1], acc};
    assign product_ext = {{(ACC_W + 1 - PRODUCT_W){product[PRODUCT_W-1]}}, product};
    assign sum_wide    = acc_ext + product_ext;

    // Extra top bit holds the true sign; a disagreement with the ACC_W-bit
    // sign bit means the result does not fit.
    assign ovf = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

`ifdef MAC_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sum = sum_wide[ACC_W-1:0];
        if (ovf) begin
            sum = sum_wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum = sum_wide[ACC_W-1:0];
`endif

endmodule : sat_add

// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
// Sums a job of `length` signed 8-bit products (valid/ready in) into a
// sign-extended ACC_W-bit accumulator and presents the result over a second
// valid/ready handshake, with a sticky per-job signed-overflow flag.
//
// Optional feature macro: MAC_SATURATE_EN (saturating vs wrapping add,
// implemented in sat_add; overflow flag is identical in both builds).
//
// Ports:
//   clock          in  1      rising-edge clock
//   reset          in  1      asynchronous, active-low reset
//   start          in  1      begin a job (sampled only in IDLE)
//   length         in  LEN_W  products in the job, captured with start
//   busy           out 1      high in ACCUM and DONE
//   product_valid  in  1      upstream product available
//   product_ready  out 1      high only in ACCUM
//   product        in  8      signed product
//   result_valid   out 1      high only in DONE
//   result_ready   in  1      downstream accepts result
//   result         out ACC_W  accumulated sum (held while result_valid)
//   overflow       out 1      sticky signed overflow for the current job
// ---------------------------------------------------------------------------
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     length,
    output logic                 busy,
    input  logic                 product_valid,
    output logic                 product_ready,
    input  logic [PRODUCT_W-1:0] product,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [ACC_W-1:0]     result,
    output logic                 overflow
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               overflow_q, overflow_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc     (acc_q),
        .product (product),
        .sum     (add_sum),
        .ovf     (add_ovf)
    );

    // Handshake outputs are pure state decodes: no combinational path from
    // product_valid or result_ready.
    assign busy          = (state_q != ST_IDLE);
    assign product_ready = (state_q == ST_ACCUM);
    assign result_valid  = (state_q == ST_DONE);
    assign result        = acc_q;
    assign overflow      = overflow_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d      = '0;
                    overflow_d = 1'b0;
                    if (length != '0) begin
                        remaining_d = length;
                        state_d     = ST_ACCUM;
                    end else begin
                        state_d     = ST_DONE;
                    end
                end
            end

            ST_ACCUM: begin
                // product_ready is implied by being in ACCUM.
                if (product_valid) begin
                    acc_d       = add_sum;
                    overflow_d  = overflow_q | add_ovf;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // acc is deliberately kept so result holds its value in IDLE.
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample the pre-edge values of each other.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule : mac_accumulator

// File: tb/tb_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac_accumulator
// Directed bench for mac_accumulator. Two instances share all inputs: a
// default-width one (ACC_W=16) and a narrow one (ACC_W=8) used for the
// overflow cases. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mac_accumulator;

    logic        clock;
    logic        reset;
    logic        start;
    logic [3:0]  length;
    logic        product_valid;
    logic [7:0]  product;
    logic        result_ready;

    logic        busy16, pready16, rvalid16, ovf16;
    logic [15:0] result16;
    logic        busy8, pready8, rvalid8, ovf8;
    logic [7:0]  result8;

    int total;
    int bad;

    mac_accumulator #(.ACC_W(16), .LEN_W(4)) dut16 (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .length        (length),
        .busy          (busy16),
        .product_valid (product_valid),
        .product_ready (pready16),
        .product       (product),
        .result_valid  (rvalid16),
        .result_ready  (result_ready),
        .result        (result16),
        .overflow      (ovf16)
    );

    mac_accumulator #(.ACC_W(8), .LEN_W(4)) dut8 (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .length        (length),
        .busy          (busy8),
        .product_valid (product_valid),
        .product_ready (pready8),
        .product       (product),
        .result_valid  (rvalid8),
        .result_ready  (result_ready),
        .result        (result8),
        .overflow      (ovf8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, then step 1 time unit past it so outputs are
    // sampled and inputs changed away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int waited;

        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        start         = 1'b0;
        length        = 4'd0;
        product_valid = 1'b0;
        product       = 8'd0;
        result_ready  = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_busy",   {31'd0, busy16},   32'd0);
        check("rst_rvalid", {31'd0, rvalid16}, 32'd0);
        check("rst_result", {16'd0, result16}, 32'd0);
        reset = 1'b1;
        tick();

        // ---------------- reset mid-job ----------------
        start = 1'b1; length = 4'd5; product_valid = 1'b1; product = 8'd3;
        tick();
        start = 1'b0;
        tick();                     // beat 3 accepted
        product = 8'd4;
        tick();                     // beat 4 accepted, acc = 7
        check("mid_acc_pre",  {16'd0, result16}, 32'd7);
        check("mid_busy_pre", {31'd0, busy16},   32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_busy",   {31'd0, busy16},   32'd0);
        check("mid_pready", {31'd0, pready16}, 32'd0);
        check("mid_rvalid", {31'd0, rvalid16}, 32'd0);
        check("mid_result", {16'd0, result16}, 32'd0);
        check("mid_ovf",    {31'd0, ovf16},    32'd0);
        product_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_busy", {31'd0, busy16}, 32'd0);

        // ---------------- basic job: 6 - 8 + 49 = 47 ----------------
        start = 1'b1; length = 4'd3; product_valid = 1'b1; product = 8'd6;
        tick();                     // start accepted
        start = 1'b0;
        check("basic_busy",   {31'd0, busy16},   32'd1);
        check("basic_pready", {31'd0, pready16}, 32'd1);
        tick();                     // 6 accepted
        product = 8'hF8;            // -8
        tick();
        product = 8'd49;
        check("basic_rv_early", {31'd0, rvalid16}, 32'd0);
        tick();                     // 4th edge after start
        product_valid = 1'b0;
        check("basic_rvalid", {31'd0, rvalid16}, 32'd1);
        check("basic_result", {16'd0, result16}, 32'd47);
        check("basic_ovf",    {31'd0, ovf16},    32'd0);
        check("basic_pready_done", {31'd0, pready16}, 32'd0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("basic_idle",      {31'd0, busy16},   32'd0);
        check("basic_held_idle", {16'd0, result16}, 32'd47);

        // ---------------- stalls: 10 + 20 = 30 ----------------
        start = 1'b1; length = 4'd2;
        tick();
        start = 1'b0;
        product_valid = 1'b1; product = 8'd10;
        tick();
        product_valid = 1'b0;
        tick(); tick(); tick();
        check("stall_busy",   {31'd0, busy16},   32'd1);
        check("stall_rvalid", {31'd0, rvalid16}, 32'd0);
        product_valid = 1'b1; product = 8'd20;
        tick();
        product_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_hold_result", {16'd0, result16}, 32'd30);
            check("stall_hold_rvalid", {31'd0, rvalid16}, 32'd1);
            tick();
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("stall_idle", {31'd0, busy16}, 32'd0);

        // ---------------- zero length ----------------
        start = 1'b1; length = 4'd0;
        tick();
        start = 1'b0;
        check("zero_rvalid", {31'd0, rvalid16}, 32'd1);
        check("zero_result", {16'd0, result16}, 32'd0);
        check("zero_pready", {31'd0, pready16}, 32'd0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;

        // ---------------- overflow on 8-bit accumulator: 64 + 64 ----------------
        start = 1'b1; length = 4'd2; product_valid = 1'b1; product = 8'd64;
        tick();
        start = 1'b0;
        waited = 0;
        while (!rvalid8 && waited < 10) begin
            tick();
            waited++;
        end
        product_valid = 1'b0;
        check("ovf_latency", waited, 2);
`ifdef MAC_SATURATE_EN
        check("ovf_result8", {24'd0, result8}, 32'h7F);
`else
        check("ovf_result8", {24'd0, result8}, 32'h80);
`endif
        check("ovf_flag8",    {31'd0, ovf8},     32'd1);
        check("ovf_result16", {16'd0, result16}, 32'd128);
        check("ovf_flag16",   {31'd0, ovf16},    32'd0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;

        // next job clears the sticky flag
        start = 1'b1; length = 4'd1; product_valid = 1'b1; product = 8'd1;
        tick();
        start = 1'b0;
        tick();
        product_valid = 1'b0;
        check("ovf_clr_rvalid", {31'd0, rvalid8}, 32'd1);
        check("ovf_clr_flag",   {31'd0, ovf8},    32'd0);
        check("ovf_clr_result", {24'd0, result8}, 32'd1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;

        // ---------------- start ignored during ACCUM: 5 + 7 = 12 ----------------
        start = 1'b1; length = 4'd2; product_valid = 1'b1; product = 8'd5;
        tick();
        length = 4'd9;              // start stays high into ACCUM
        tick();                     // 5 accepted
        start = 1'b0;
        product = 8'd7;
        tick();                     // 7 accepted, job complete
        product_valid = 1'b0;
        check("ign_rvalid", {31'd0, rvalid16}, 32'd1);
        check("ign_result", {16'd0, result16}, 32'd12);
        check("ign_pready", {31'd0, pready16}, 32'd0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        tick();
        check("ign_idle", {31'd0, busy16}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mac_accumulator

// File: doc/mac_accumulator.md
# mac_accumulator

Downstream consumer of the 4x4 radix-2 Booth multiplier stage. Accepts a job of `length` signed 8-bit products over a valid/ready handshake and sums them into a sign-extended `ACC_W`-bit accumulator. It presents the dot-product result over a second valid/ready handshake and flags signed overflow. Sits between the multiplier's `product` output and the result bus of the small-DSP lab datapath.

## Interface
- `ACC_W`, 16, accumulator/result width in bits; legal range 8..32.
- `LEN_W`, 4, width of the job length field; maximum job is 2^LEN_W−1 products.

- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low; asserted low forces the reset state immediately.
- `start`  in  1  begin a job; sampled only in IDLE.
- `length`  in  LEN_W  number of products in the job; captured with `start`.
- `busy`  out  1  high in ACCUM and DONE.
- `product_valid`  in  1  upstream product available.
- `product_ready`  out  1  high only in ACCUM.
- `product`  in  8  signed two's-complement product.
- `result_valid`  out  1  high only in DONE.
- `result_ready`  in  1  downstream accepts result.
- `result`  out  ACC_W  signed accumulated sum; held stable while `result_valid` is high.
- `overflow`  out  1  sticky per job; set on any signed overflow of the accumulator.

## Operation
- States: IDLE, ACCUM, DONE.
- **IDLE**
  - `start`=1 and `length`≠0: acc←0, overflow←0, remaining←`length`, go to ACCUM.
  - `start`=1 and `length`=0: acc←0, overflow←0, go straight to DONE.
- **ACCUM**
  - A beat is accepted when `product_valid` and `product_ready` are both high.
  - On each beat: acc←acc+sext(product); remaining←remaining−1.
  - If remaining was 1 when the beat is accepted, go to DONE.
  - With no beat accepted, all state holds.
- **DONE**
  - `result`=acc and `result_valid`=1.
  - `result_ready`=1 returns to IDLE. acc is not cleared, so `result` keeps its last value in IDLE.
- `start` outside IDLE is ignored; `length` changes outside IDLE are ignored.
- **Arithmetic:** compute in ACC_W+1 bits. Overflow is when the two top bits of the ACC_W+1 sum differ. `overflow` is OR-ed every beat and cleared only by an accepted `start`.
- **Reset:** when `reset` goes low at any point, including mid-job:
  - state←IDLE, acc←0, remaining←0, overflow←0.
  - All outputs go 0: `busy`, `product_ready`, `result_valid`, `result`, `overflow`.
  - Any partial job is discarded with no result.

## Timing
- `start` accepted on edge N: `busy` and `product_ready` high from N+1.
- Throughput is one product per cycle, so back-to-back beats with no bubbles.
- Last beat accepted on edge M: `result_valid` high from M+1.
- Total latency for a job of L products under continuous valid: L+1 cycles from `start` to `result_valid`.
- `length`=0: `result_valid` high one cycle after `start`.
- `result_ready` accepted on edge K: IDLE from K+1. A new `start` is sampled from K+1 onward, so there is no same-cycle DONE→ACCUM turnaround.
- `product_ready` and `result_valid` are registered-state decodes with no combinational path from `product_valid` or `result_ready`.

## Configuration
- `MAC_SATURATE_EN`:
  - Defined: on overflow, acc clamps to +2^(ACC_W−1)−1 (positive overflow) or −2^(ACC_W−1) (negative overflow). Later beats continue from the clamped value.
  - Undefined: acc wraps modulo 2^ACC_W.
- `overflow` behaves identically in both builds.

## Structure
- Shared package `mac_pkg`:
  - state enum (IDLE, ACCUM, DONE);
  - `PRODUCT_W`=8;
  - default `ACC_W` and `LEN_W` constants.
- One sub-module, `sat_add`: combinational sign-extend-and-add of ACC_W + 8 bits. Outputs are the sum and an overflow bit; the clamp is applied inside the `MAC_SATURATE_EN` guard. Sequencing stays in the top.

## Test plan
- Reset mid-job: `length`=5, 2 beats accepted, `reset` low → all outputs 0 asynchronously. After release, IDLE with `busy`=0.
- Basic job: `length`=3, products 6, −8, 49 with continuous valid → `result`=47 and `overflow`=0, `result_valid` 4 cycles after `start`.
- Stalls: `length`=2, products 10, 20, with `product_valid` low for 3 cycles between beats → `result`=30. Then hold `result_ready` low 5 cycles → `result` stable, no re-entry to IDLE.
- Zero length: `start` with `length`=0 → `result_valid` next cycle, `result`=0, no `product_ready` pulse.
- Overflow, `ACC_W`=8, products 64, 64:
  - without `MAC_SATURATE_EN` → `result`=−128, `overflow`=1;
  - with it → `result`=127, `overflow`=1;
  - next job with product 1 → `overflow`=0.
- Ignored start: pulse `start` with `length`=9 during ACCUM of a `length`=2 job → job completes after 2 beats with unchanged sum.
